// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, branch flush and forwarding select for a 5-stage pipe
module pipe_hazard_ctrl #(
  parameter int XLEN_REGS = 32,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [$clog2(XLEN_REGS)-1:0] id_rs1,
  input  logic [$clog2(XLEN_REGS)-1:0] id_rs2,
  input  logic                         id_rs1_used,
  input  logic                         id_rs2_used,
  input  logic [$clog2(XLEN_REGS)-1:0] id_rd,
  input  logic                         id_wr,
  input  logic                         id_is_load,
  input  logic                         br_taken,
  input  logic                         ext_stall,
  output logic                         stall_if,
  output logic                         stall_id,
  output logic                         bubble_ex,
  output logic                         flush_id,
  output logic [1:0]                   fwd1_sel,
  output logic [1:0]                   fwd2_sel,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int RW = $clog2(XLEN_REGS);
  localparam logic [RW-1:0]    REG_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state;

  // EX-stage tracker
  logic          ext_valid;
  logic          ext_wr;
  logic [RW-1:0] ext_rd;
  logic          ext_load;

  // MEM-stage tracker; its load flag never matters once the data is available
  logic          memt_valid;
  logic          memt_wr;
  logic [RW-1:0] memt_rd;

  logic [CNT_W-1:0] cnt;

  logic ext_writes;
  logic memt_writes;
  logic load_use;
  logic count_stall;

  assign ext_writes  = ext_valid && ext_wr && (ext_rd != REG_ZERO);
  assign memt_writes = memt_valid && memt_wr && (memt_rd != REG_ZERO);

  assign load_use = id_valid && ext_writes && ext_load &&
                    ((id_rs1_used && (id_rs1 == ext_rd)) ||
                     (id_rs2_used && (id_rs2 == ext_rd)));

  // A load-use only costs a cycle when nothing higher-priority is in play
  assign count_stall = rst && !ext_stall && (state == RUN) && !br_taken && load_use;

  function automatic logic [1:0] fwd_pick(input logic [RW-1:0] rs);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ext_writes && !ext_load && (ext_rd == rs)) begin
      sel = FWD_EX;
    end else if (memt_writes && (memt_rd == rs)) begin
      sel = FWD_MEM;
    end
    return sel;
  endfunction

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    fwd1_sel  = FWD_RF;
    fwd2_sel  = FWD_RF;
    if (!rst) begin
      bubble_ex = 1'b1;
    end else begin
      fwd1_sel = fwd_pick(id_rs1);
      fwd2_sel = fwd_pick(id_rs2);
      if (ext_stall) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end else if (state == FLUSH || br_taken) begin
        bubble_ex = 1'b1;
        flush_id  = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      ext_valid  <= 1'b0;
      ext_wr     <= 1'b0;
      ext_rd     <= '0;
      ext_load   <= 1'b0;
      memt_valid <= 1'b0;
      memt_wr    <= 1'b0;
      memt_rd    <= '0;
      cnt        <= '0;
    end else if (!ext_stall) begin
      memt_valid <= ext_valid;
      memt_wr    <= ext_wr;
      memt_rd    <= ext_rd;
      if (bubble_ex) begin
        ext_valid <= 1'b0;
        ext_wr    <= 1'b0;
        ext_rd    <= '0;
        ext_load  <= 1'b0;
      end else begin
        ext_valid <= id_valid;
        ext_wr    <= id_wr;
        ext_rd    <= id_rd;
        ext_load  <= id_is_load;
      end

      case (state)
        RUN:     if (br_taken) state <= FLUSH;
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase

      if (count_stall && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed checks of pipe_hazard_ctrl forwarding, stalls, flushes and saturation
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_wr;
  logic       id_is_load;
  logic       br_taken;
  logic       ext_stall;

  logic        stall_if, stall_id, bubble_ex, flush_id;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic [15:0] stall_cnt;

  logic        s_stall_if, s_stall_id, s_bubble_ex, s_flush_id;
  logic [1:0]  s_fwd1_sel, s_fwd2_sel;
  logic [2:0]  s_stall_cnt;

  int tests;
  int fails;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load),
    .br_taken(br_taken), .ext_stall(ext_stall),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .stall_cnt(stall_cnt)
  );

  // Narrow counter copy so saturation is reachable in a short run
  pipe_hazard_ctrl #(.XLEN_REGS(32), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load),
    .br_taken(br_taken), .ext_stall(ext_stall),
    .stall_if(s_stall_if), .stall_id(s_stall_id), .bubble_ex(s_bubble_ex), .flush_id(s_flush_id),
    .fwd1_sel(s_fwd1_sel), .fwd2_sel(s_fwd2_sel), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wr, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_wr = wr; id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ctl(input string tag, input int sif, input int sid, input int bub, input int fl);
    check({tag, ".stall_if"}, stall_if, sif);
    check({tag, ".stall_id"}, stall_id, sid);
    check({tag, ".bubble_ex"}, bubble_ex, bub);
    check({tag, ".flush_id"}, flush_id, fl);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0; br_taken = 1'b0; ext_stall = 1'b0;
    idle();
    tick();
    ctl("reset", 0, 0, 1, 0);
    check("reset.fwd1", fwd1_sel, 0);
    check("reset.fwd2", fwd2_sel, 0);
    check("reset.cnt", stall_cnt, 0);
    tick();
    rst = 1'b1;

    // ADD x5 ; SUB rs1=x5
    set_id(1, 1, 1, 2, 1, 5, 1, 0);
    ctl("add", 0, 0, 0, 0);
    tick();
    set_id(1, 5, 1, 3, 1, 6, 1, 0);
    check("b2b.fwd1", fwd1_sel, 1);
    ctl("b2b", 0, 0, 0, 0);
    tick();

    // unrelated x9 writer, then use x6 (MEM) and x9 (EX)
    set_id(1, 1, 1, 2, 1, 9, 1, 0);
    check("gap0.fwd1", fwd1_sel, 0);
    tick();
    set_id(1, 6, 1, 9, 1, 0, 0, 0);
    check("gap.fwd1", fwd1_sel, 2);
    check("gap.fwd2", fwd2_sel, 1);
    tick();

    // LW x7 ; ADD rs2=x7
    set_id(1, 2, 1, 4, 0, 7, 1, 1);
    ctl("lw", 0, 0, 0, 0);
    tick();
    set_id(1, 3, 1, 7, 1, 8, 1, 0);
    ctl("lu", 1, 1, 1, 0);
    check("lu.fwd2", fwd2_sel, 0);
    check("lu.cnt_before", stall_cnt, 0);
    tick();
    ctl("lu_after", 0, 0, 0, 0);
    check("lu_after.fwd2", fwd2_sel, 2);
    check("lu_after.cnt", stall_cnt, 1);
    tick();

    // branch taken with a concurrent load-use
    set_id(1, 2, 1, 4, 0, 10, 1, 1);
    tick();
    br_taken = 1'b1;
    set_id(1, 10, 1, 0, 0, 11, 1, 0);
    ctl("br", 0, 0, 1, 1);
    tick();
    idle();
    ctl("flush", 0, 0, 1, 1);
    tick();
    br_taken = 1'b0;
    #1;
    ctl("post_flush", 0, 0, 0, 0);
    check("br.cnt", stall_cnt, 1);
    tick();

    // ext_stall over a load-use
    set_id(1, 2, 1, 4, 0, 7, 1, 1);
    tick();
    ext_stall = 1'b1;
    set_id(1, 7, 1, 4, 0, 12, 1, 0);
    for (int i = 0; i < 3; i++) begin
      ctl($sformatf("xs%0d", i), 1, 1, 0, 0);
      check($sformatf("xs%0d.fwd1", i), fwd1_sel, 0);
      check($sformatf("xs%0d.cnt", i), stall_cnt, 1);
      tick();
    end
    ext_stall = 1'b0;
    #1;
    ctl("xs_rel", 1, 1, 1, 0);
    tick();
    ctl("xs_done", 0, 0, 0, 0);
    check("xs_done.fwd1", fwd1_sel, 2);
    check("xs_done.cnt", stall_cnt, 2);
    tick();

    // x0 load writer then x0 reader
    set_id(1, 1, 1, 2, 0, 0, 1, 1);
    tick();
    set_id(1, 0, 1, 0, 1, 13, 1, 0);
    ctl("x0", 0, 0, 0, 0);
    check("x0.fwd1", fwd1_sel, 0);
    check("x0.fwd2", fwd2_sel, 0);
    tick();

    // repeated load-uses to saturate the narrow counter
    for (int i = 0; i < 6; i++) begin
      set_id(1, 1, 0, 2, 0, 7, 1, 1);
      tick();
      set_id(1, 3, 0, 7, 1, 8, 1, 0);
      tick();
      tick();
    end
    check("sat.narrow", s_stall_cnt, 7);
    check("sat.wide", stall_cnt, 8);
    set_id(1, 1, 0, 2, 0, 7, 1, 1);
    tick();
    set_id(1, 3, 0, 7, 1, 8, 1, 0);
    check("sat.stall", s_stall_if, 1);
    tick();
    check("sat.narrow_hold", s_stall_cnt, 7);
    check("sat.wide_inc", stall_cnt, 9);
    tick();

    // reset asserted while in FLUSH
    idle();
    br_taken = 1'b1;
    tick();
    br_taken = 1'b0;
    rst = 1'b0;
    #1;
    ctl("rst_flush", 0, 0, 1, 0);
    tick();
    rst = 1'b1;
    idle();
    ctl("rst_release", 0, 0, 0, 0);
    check("rst_release.cnt", stall_cnt, 0);
    tick();

    // reset clears a live writer in EX
    set_id(1, 1, 0, 2, 0, 5, 1, 1);
    tick();
    rst = 1'b0;
    idle();
    tick();
    rst = 1'b1;
    set_id(1, 5, 1, 5, 1, 14, 1, 0);
    ctl("rst_trk", 0, 0, 0, 0);
    check("rst_trk.fwd1", fwd1_sel, 0);
    tick();
    check("rst_trk.fwd1_mem", fwd1_sel, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
